// File: rtl/chacha_pkg.sv
// Shared ChaCha word type, rotate helper and inverse quarter-round step encoding.
package chacha_pkg;

  typedef logic [31:0] word_t;

  localparam int ROT_16 = 16;
  localparam int ROT_12 = 12;
  localparam int ROT_8  = 8;
  localparam int ROT_7  = 7;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } step_t;

  function automatic word_t rotr(word_t w, int n);
    return (w >> n) | (w << (32 - n));
  endfunction

endpackage

// File: rtl/inv_qr_step.sv
// One inverse ARX step of the ChaCha quarter-round, selected by step; purely combinational.
module inv_qr_step
  import chacha_pkg::*;
(
  input  step_t step,
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_nxt,
  output word_t b_nxt,
  output word_t c_nxt,
  output word_t d_nxt
);

  // Ops within a step run in order; later ops see the words updated earlier in the same step.
  always_comb begin
    word_t ta, tb, tc, td;
    ta = a;
    tb = b;
    tc = c;
    td = d;
    case (step)
      S0: begin
        tb = rotr(tb, ROT_7) ^ tc;
        tc = tc - td;
        td = rotr(td, ROT_8) ^ ta;
      end
      S1: begin
        ta = ta - tb;
      end
      S2: begin
        tb = rotr(tb, ROT_12) ^ tc;
        tc = tc - td;
      end
      S3: begin
        td = rotr(td, ROT_16) ^ ta;
        ta = ta - tb;
      end
      default: ;
    endcase
    a_nxt = ta;
    b_nxt = tb;
    c_nxt = tc;
    d_nxt = td;
  end

endmodule

// File: rtl/inv_round.sv
// Iterative inverse ChaCha quarter-round: one step per clock, result 4*ITERS cycles after accept.
// One job in flight; the result is held with out_valid until out_ready, no input accepted meanwhile.
module inv_round
  import chacha_pkg::*;
#(
  parameter int WIDTH = 32,  // rotate amounts assume 32-bit words
  parameter int ITERS = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [WIDTH-1:0] input_c,
  input  logic [WIDTH-1:0] input_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_a,
  output logic [WIDTH-1:0] output_b,
  output logic [WIDTH-1:0] output_c,
  output logic [WIDTH-1:0] output_d
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int IW = $clog2(ITERS + 1);
  localparam logic [IW-1:0] LAST_ITER = IW'(ITERS - 1);

  logic [1:0]    state;
  logic [1:0]    step_cnt;
  logic [IW-1:0] iter_cnt;
  word_t         wa, wb, wc, wd;
  word_t         na, nb, nc, nd;
  word_t         res_a, res_b, res_c, res_d;
  logic          last_step;

  inv_qr_step u_step (
    .step  (step_t'(step_cnt)),
    .a     (wa),
    .b     (wb),
    .c     (wc),
    .d     (wd),
    .a_nxt (na),
    .b_nxt (nb),
    .c_nxt (nc),
    .d_nxt (nd)
  );

  assign last_step = (step_cnt == 2'd3) && (iter_cnt == LAST_ITER);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign output_a  = res_a;
  assign output_b  = res_b;
  assign output_c  = res_c;
  assign output_d  = res_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      step_cnt <= 2'd0;
      iter_cnt <= '0;
      wa       <= '0;
      wb       <= '0;
      wc       <= '0;
      wd       <= '0;
      res_a    <= '0;
      res_b    <= '0;
      res_c    <= '0;
      res_d    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            wa       <= input_a;
            wb       <= input_b;
            wc       <= input_c;
            wd       <= input_d;
            step_cnt <= 2'd0;
            iter_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          wa       <= na;
          wb       <= nb;
          wc       <= nc;
          wd       <= nd;
          step_cnt <= step_cnt + 2'd1;
          if (step_cnt == 2'd3) begin
            iter_cnt <= iter_cnt + IW'(1);
          end
          // The last step's result goes straight to the output registers so it is visible on entering DONE.
          if (last_step) begin
            res_a <= na;
            res_b <= nb;
            res_c <= nc;
            res_d <= nd;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_round.sv
// Bench for inv_round: known-answer table, forward/inverse round trips, handshake corner cases.
module tb_inv_round;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } quad_t;

  typedef struct {
    quad_t in;
    quad_t exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] input_a, input_b, input_c, input_d;
  logic [31:0] output_a, output_b, output_c, output_d;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [31:0] input2_a, input2_b, input2_c, input2_d;
  logic [31:0] output2_a, output2_b, output2_c, output2_d;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  inv_round #(.WIDTH(32), .ITERS(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .input_a(input_a), .input_b(input_b), .input_c(input_c), .input_d(input_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .output_a(output_a), .output_b(output_b), .output_c(output_c), .output_d(output_d)
  );

  inv_round #(.WIDTH(32), .ITERS(2)) dut2 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .input_a(input2_a), .input_b(input2_b), .input_c(input2_c), .input_d(input2_d),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .output_a(output2_a), .output_b(output2_b), .output_c(output2_c), .output_d(output2_d)
  );

  function automatic logic [31:0] rotl(logic [31:0] x, int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference: the forward ChaCha quarter-round.
  function automatic quad_t fwd(quad_t q);
    quad_t r;
    r = q;
    r.a = r.a + r.b; r.d = rotl(r.d ^ r.a, 16);
    r.c = r.c + r.d; r.b = rotl(r.b ^ r.c, 12);
    r.a = r.a + r.b; r.d = rotl(r.d ^ r.a, 8);
    r.c = r.c + r.d; r.b = rotl(r.b ^ r.c, 7);
    return r;
  endfunction

  function automatic quad_t cur();
    return {output_a, output_b, output_c, output_d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input quad_t act, input quad_t exp);
    chk({name, ".a"}, act.a, exp.a);
    chk({name, ".b"}, act.b, exp.b);
    chk({name, ".c"}, act.c, exp.c);
    chk({name, ".d"}, act.d, exp.d);
  endtask

  task automatic drive_words(input quad_t x);
    input_a = x.a; input_b = x.b; input_c = x.c; input_d = x.d;
  endtask

  // One job on the ITERS=1 instance; checks held outputs mid-job, returns result and latency.
  task automatic do_job(input quad_t x, input quad_t held, input bit rdy_early, input bit busy_pulse,
                        output quad_t r, output int lat);
    @(negedge clock);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    drive_words(x);
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = rdy_early;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (busy_pulse && lat == 1) begin
        in_valid = 1'b1;
        drive_words({4{32'hFFFF_FFFF}});
      end
      if (lat == 2) begin
        in_valid = 1'b0;
        chk_q("hold_in_busy", cur(), held);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clock);
      lat++;
    end
    r = cur();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("out_valid_after_take", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vt[6];
    quad_t r, exp_last, q, z;
    int    lat;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive_words('0);
    in_valid2 = 1'b0; out_ready2 = 1'b0;
    {input2_a, input2_b, input2_c, input2_d} = '0;

    vt[0].in  = {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};
    vt[0].exp = {32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567};
    vt[1].exp = '0;
    vt[2].exp = {4{32'hFFFF_FFFF}};
    vt[3].exp = {32'h0000_0001, 32'h0, 32'h0, 32'h0};
    vt[4].exp = {32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
    vt[5].exp = {32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210};
    for (int i = 1; i < 6; i++) vt[i].in = fwd(vt[i].exp);

    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk_q("rst_out", cur(), '0);
    @(negedge clock);
    reset_n = 1'b1;
    exp_last = '0;

    for (int i = 0; i < 6; i++) begin
      do_job(vt[i].in, exp_last, 1'b0, 1'b0, r, lat);
      chk($sformatf("table%0d_lat", i), lat, 32'd4);
      chk_q($sformatf("table%0d", i), r, vt[i].exp);
      exp_last = vt[i].exp;
    end

    // Busy-phase in_valid pulse must not disturb the job.
    do_job(vt[0].in, exp_last, 1'b0, 1'b1, r, lat);
    chk("busy_ignore_lat", lat, 32'd4);
    chk_q("busy_ignore", r, vt[0].exp);
    exp_last = vt[0].exp;

    // out_ready high throughout the job has no effect before out_valid.
    do_job(vt[5].in, exp_last, 1'b1, 1'b0, r, lat);
    chk("early_rdy_lat", lat, 32'd4);
    chk_q("early_rdy", r, vt[5].exp);
    exp_last = vt[5].exp;

    // Backpressure: hold out_ready low for 10 cycles after out_valid.
    @(negedge clock);
    in_valid = 1'b1; drive_words(vt[0].in);
    @(negedge clock);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clock); lat++; end
    chk("bp_lat", lat, 32'd4);
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk_q("bp_out", cur(), vt[0].exp);
      if (k == 4) begin in_valid = 1'b1; drive_words({4{32'hFFFF_FFFF}}); end
      @(negedge clock);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    chk_q("bp_idle_hold", cur(), vt[0].exp);
    exp_last = vt[0].exp;

    // Reset asserted at cycle 2 of BUSY: job dropped, reset values at once.
    @(negedge clock);
    in_valid = 1'b1; drive_words(vt[4].in);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    chk_q("rst_mid_out", cur(), '0);
    @(negedge clock);
    reset_n = 1'b1;
    exp_last = '0;
    do_job(vt[0].in, exp_last, 1'b0, 1'b0, r, lat);
    chk("post_rst_lat", lat, 32'd4);
    chk_q("post_rst", r, vt[0].exp);
    exp_last = vt[0].exp;

    // Random round trips.
    for (int i = 0; i < 1000; i++) begin
      q = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_job(fwd(q), exp_last, 1'b0, 1'b0, r, lat);
      if (lat != 4) chk("rand_lat", lat, 32'd4);
      chk_q("rand_rt", r, q);
      exp_last = q;
    end

    // ITERS=2 instance: two forward rounds undone in 8 cycles.
    z = {32'd1, 32'd0, 32'd0, 32'd0};
    q = fwd(fwd(z));
    @(negedge clock);
    chk("it2_in_ready", {31'd0, in_ready2}, 32'd1);
    in_valid2 = 1'b1;
    {input2_a, input2_b, input2_c, input2_d} = q;
    @(negedge clock);
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 40) begin @(negedge clock); lat++; end
    chk("it2_lat", lat, 32'd8);
    chk_q("it2", {output2_a, output2_b, output2_c, output2_d}, z);
    out_ready2 = 1'b1;
    @(negedge clock);
    out_ready2 = 1'b0;
    chk("it2_take", {31'd0, out_valid2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
